// File: rtl/usb_token_tx.sv
// usb_token_tx: serializes a USB token packet (SYNC, PID, ADDR, ENDP, CRC5) with bit stuffing and EOP.
module usb_token_tx #(
   parameter int EOP_BITS = 2
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       tx_start,
   input  logic [3:0] pid,
   input  logic [6:0] addr,
   input  logic [3:0] endp,
   input  logic       shift_enable,
   output logic       tx_bit,
   output logic       tx_active,
   output logic       tx_eop,
   output logic       tx_done
);
   typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC, EOP, DONE} state_t;
   localparam logic [7:0] SYNC_PAT = 8'h80;
   state_t      state, state_n, adv_state;
   logic [3:0]  idx, idx_n, adv_idx, flen;
   logic [2:0]  ones, ones_n;
   logic        stuff, stuff_n, bit_n, fb;
   logic [4:0]  crc, crc_n;
   logic [3:0]  pid_q, pid_n, endp_q, endp_n;
   logic [6:0]  addr_q, addr_n;
   logic [15:0] field;
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state  <= IDLE;
         idx    <= '0;
         ones   <= '0;
         stuff  <= 1'b0;
         crc    <= 5'h1f;
         tx_bit <= 1'b1;
         pid_q  <= '0;
         addr_q <= '0;
         endp_q <= '0;
      end else begin
         state  <= state_n;
         idx    <= idx_n;
         ones   <= ones_n;
         stuff  <= stuff_n;
         crc    <= crc_n;
         tx_bit <= bit_n;
         pid_q  <= pid_n;
         addr_q <= addr_n;
         endp_q <= endp_n;
      end
   end
   // idx/state always name the next field bit; stuff marks that tx_bit is an inserted 0 instead
   always_comb begin
      state_n   = state;
      idx_n     = idx;
      ones_n    = ones;
      stuff_n   = stuff;
      crc_n     = crc;
      bit_n     = tx_bit;
      pid_n     = pid_q;
      addr_n    = addr_q;
      endp_n    = endp_q;
      adv_state = state;
      adv_idx   = idx;
      field     = '0;
      fb        = tx_bit ^ crc[4];
      flen      = state == DATA ? 4'd11 : state == CRC ? 4'd5 : state == EOP ? 4'(EOP_BITS) : 4'd8;
      if (state == IDLE) begin
         if (tx_start) begin
            state_n = SYNC;
            idx_n   = '0;
            ones_n  = '0;
            stuff_n = 1'b0;
            crc_n   = 5'h1f;
            bit_n   = SYNC_PAT[0];
            pid_n   = pid;
            addr_n  = addr;
            endp_n  = endp;
         end
      end else if (state == DONE) begin
         state_n = IDLE;
         bit_n   = 1'b1;
      end else if (shift_enable) begin
         ones_n = tx_bit ? ones + 3'd1 : 3'd0;
         if (!stuff) begin
            if (state == DATA) crc_n = {crc[3], crc[2], crc[1] ^ fb, crc[0], fb};
            adv_state = idx == flen - 4'd1 ? state_t'(state + 3'd1) : state;
            adv_idx   = idx == flen - 4'd1 ? 4'd0 : idx + 4'd1;
         end
         field = adv_state == SYNC ? {8'h0, SYNC_PAT} :
                 adv_state == PID  ? {8'h0, ~pid_q, pid_q} :
                 adv_state == DATA ? {5'h0, endp_q, addr_q} :
                 adv_state == CRC  ? {11'h0, ~crc_n[0], ~crc_n[1], ~crc_n[2], ~crc_n[3], ~crc_n[4]} :
                 adv_state == DONE ? 16'hffff : 16'h0;
         stuff_n = ones_n == 3'd6;
         bit_n   = !stuff_n && field[adv_idx];
         state_n = adv_state;
         idx_n   = adv_idx;
      end
   end
   assign tx_active = state != IDLE && state != DONE;
   assign tx_eop    = state == EOP && !stuff;
   assign tx_done   = state == DONE;
endmodule
